// File: rtl/pin_serializer.sv
// Serial framer: start(1), BITS data LSB first, optional even parity (PIN_SERIALIZER_PARITY_EN), stop(0).
// Start bit reaches q DELAY cycles after accept; ready only in IDLE/STOP, so upstream waits out each frame.
module pin_serializer #(
  parameter int BITS  = 32,
  parameter int DELAY = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [BITS-1:0] d,
  input  logic            valid,
  output logic            ready,
  output logic            q,
  output logic            busy
);

  localparam int CW = $clog2(BITS) + 1;
  localparam logic [CW-1:0] LAST = CW'(BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef PIN_SERIALIZER_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [BITS-1:0] sr;
  logic [CW-1:0]   cnt;
  logic [DELAY-1:0] pipe;
  logic            line;
  logic            open;
  logic            accept;
`ifdef PIN_SERIALIZER_PARITY_EN
  logic            par;
`endif

  // open is derived from state alone so accept never feeds back into itself
  assign open   = (state == IDLE) || (state == STOP);
  assign ready  = open && !reset;
  assign accept = valid && ready;
  assign q      = pipe[DELAY-1];
`ifdef PIN_SERIALIZER_PARITY_EN
  assign busy   = (state == START) || (state == DATA) || (state == PARITY);
`else
  assign busy   = (state == START) || (state == DATA);
`endif

  always_comb begin
    state_nxt = state;
    line      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = START;
      end
      START: begin
        line      = 1'b1;
        state_nxt = DATA;
      end
      DATA: begin
        line = sr[0];
        if (cnt == LAST) begin
`ifdef PIN_SERIALIZER_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end
      end
`ifdef PIN_SERIALIZER_PARITY_EN
      PARITY: begin
        line      = par;
        state_nxt = STOP;
      end
`endif
      STOP: begin
        state_nxt = accept ? START : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
      pipe  <= '0;
`ifdef PIN_SERIALIZER_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      // pipe[0] is the line register itself, so DELAY counts it as stage 1
      pipe[0] <= line;
      for (int i = 1; i < DELAY; i++) pipe[i] <= pipe[i-1];
      if (accept) sr <= d;
      else if (state == DATA) sr <= sr >> 1;
      if (state == START) cnt <= '0;
      else if (state == DATA) cnt <= cnt + CW'(1);
`ifdef PIN_SERIALIZER_PARITY_EN
      if (accept) par <= ^d;
`endif
    end
  end

endmodule

// File: tb/tb_pin_serializer.sv
// Directed bench: 8-bit/DELAY=4 and 33-bit/DELAY=1 serializers against hand-computed pin sequences.
module tb_pin_serializer;

`ifdef PIN_SERIALIZER_PARITY_EN
  localparam int          FRAME  = 11;
  localparam logic [63:0] B2B_Q  = 64'h4FF8;
  localparam int          BUSY33 = 34;
`else
  localparam int          FRAME  = 10;
  localparam logic [63:0] B2B_Q  = 64'h2FF8;
  localparam int          BUSY33 = 33;
`endif

  logic        clk = 1'b0;
  logic        rst_a = 1'b1, vld_a = 1'b0, rdy_a, q_a, busy_a;
  logic [7:0]  d_a = 8'h00;
  logic        rst_b = 1'b1, vld_b = 1'b0, rdy_b, q_b, busy_b;
  logic [32:0] d_b = 33'h0;

  int n_chk = 0;
  int n_err = 0;
  int bc, ak;

  pin_serializer #(.BITS(8), .DELAY(4)) dut_a (
    .clk(clk), .reset(rst_a), .d(d_a), .valid(vld_a),
    .ready(rdy_a), .q(q_a), .busy(busy_a)
  );

  pin_serializer #(.BITS(33), .DELAY(1)) dut_b (
    .clk(clk), .reset(rst_b), .d(d_b), .valid(vld_b),
    .ready(rdy_b), .q(q_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Steps n edges after an accept; entry k checks q after edge T+1+k against exp_q[k].
  task automatic watch(input string tag, input bit sel, input logic [63:0] exp_q,
                       input int n, input int pulse_k, output int busy_cnt, output int acc_k);
    bit   pend;
    int   ovl;
    logic qv, bz, rd, vv;
    pend = 0; ovl = 0; busy_cnt = 0; acc_k = -1;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (pend) begin
        if (sel) vld_b = 1'b0; else vld_a = 1'b0;
        pend = 0;
      end
      if (pulse_k >= 0 && k == pulse_k + 1) vld_a = 1'b0;
      qv = sel ? q_b : q_a;
      bz = sel ? busy_b : busy_a;
      rd = sel ? rdy_b : rdy_a;
      vv = sel ? vld_b : vld_a;
      check($sformatf("%s_q%0d", tag, k), 64'(qv), exp_q[k]);
      if (bz) busy_cnt++;
      if (rd && bz) ovl++;
      if (vv && rd && acc_k < 0) begin
        pend  = 1;
        acc_k = k;
      end
      if (k == pulse_k) begin
        vld_a = 1'b1;
        d_a   = 8'h3C;
      end
    end
    check($sformatf("%s_rdy_busy_overlap", tag), 64'(ovl), 64'd0);
  endtask

  task automatic accept_a(input logic [7:0] din);
    vld_a = 1'b1; d_a = din;
    @(posedge clk); #1;
    vld_a = 1'b0;
    check("acc_ready_low", 64'(rdy_a), 64'd0);
    check("acc_busy_high", 64'(busy_a), 64'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(rdy_a), 64'd0);
    check("rst_busy", 64'(busy_a), 64'd0);
    check("rst_q", 64'(q_a), 64'd0);
    rst_a = 1'b0; rst_b = 1'b0;
    #1;
    check("post_rst_ready", 64'(rdy_a), 64'd1);
    check("post_rst_busy", 64'(busy_a), 64'd0);
    check("post_rst_q", 64'(q_a), 64'd0);
    check("post_rst_ready_b", 64'(rdy_b), 64'd1);

    // A5 frame: start on q 4 cycles after accept, LSB first
    accept_a(8'hA5);
    watch("a5", 1'b0, 64'h0A58, 16, -5, bc, ak);
    check("a5_busy_cycles", 64'(bc + 1), 64'(FRAME - 1));
    check("a5_no_reaccept", 64'(ak < 0), 64'd1);

`ifdef PIN_SERIALIZER_PARITY_EN
    accept_a(8'h07);
    watch("p07", 1'b0, 64'h1078, 16, -5, bc, ak);
    check("p07_busy_cycles", 64'(bc + 1), 64'd10);
    accept_a(8'h03);
    watch("p03", 1'b0, 64'h0038, 16, -5, bc, ak);
    check("p03_busy_cycles", 64'(bc + 1), 64'd10);
`endif

    // back-to-back: valid held, second word taken in the STOP cycle
    vld_a = 1'b1; d_a = 8'hFF;
    @(posedge clk); #1;
    d_a = 8'h00;
    check("b2b_ready_low", 64'(rdy_a), 64'd0);
    watch("b2b", 1'b0, B2B_Q, 26, -5, bc, ak);
    check("b2b_spacing", 64'(ak + 2), 64'(FRAME));

    // valid pulse during DATA must be ignored
    accept_a(8'hA5);
    watch("ign", 1'b0, 64'h0A58, 20, 3, bc, ak);
    check("ign_no_accept", 64'(ak < 0), 64'd1);

    // 33-bit word, DELAY=1: counter must run past 31 without wrapping
    vld_b = 1'b1; d_b = 33'h1_0000_0001;
    @(posedge clk); #1;
    vld_b = 1'b0;
    check("w33_busy_start", 64'(busy_b), 64'd1);
    watch("w33", 1'b1, 64'h2_0000_0003, 40, -5, bc, ak);
    check("w33_busy_cycles", 64'(bc), 64'(BUSY33));

    // reset during DATA bit 3 of FF aborts and flushes the pin pipeline
    accept_a(8'hFF);
    watch("pre_rst", 1'b0, 64'h8, 4, -5, bc, ak);
    rst_a = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_busy", 64'(busy_a), 64'd0);
    check("mid_rst_q", 64'(q_a), 64'd0);
    check("mid_rst_ready", 64'(rdy_a), 64'd0);
    rst_a = 1'b0;
    #1;
    check("mid_rel_ready", 64'(rdy_a), 64'd1);
    check("mid_rel_busy", 64'(busy_a), 64'd0);
    check("mid_rel_q", 64'(q_a), 64'd0);
    watch("flush", 1'b0, 64'h0, 6, -5, bc, ak);
    check("flush_busy", 64'(bc), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
